// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One shared 33-bit adder runs shift-add multiply and restoring divide.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic [WIDTH-1:0] araw_q, araw_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] wrk_q, wrk_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic             is_div;
   logic             is_sgn;
   logic             in_sgn;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   add_x;
   logic [WIDTH:0]   add_y;
   logic [WIDTH:0]   add_s;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_n;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;

   assign is_div = op_q[1];
   assign is_sgn = ~op_q[0];
   assign in_sgn = ~op[0];

   assign abs_a = (in_sgn & op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
   assign abs_b = (in_sgn & op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;

   // Divide feeds {rem,quo} shifted left and subtracts; multiply adds
   assign add_x = is_div ? {acc_q, wrk_q[WIDTH-1]} : {1'b0, acc_q};
   assign add_y = is_div ? ~{1'b0, opnd_q}
                         : (wrk_q[0] ? {1'b0, opnd_q} : '0);
   assign add_s = add_x + add_y + {{WIDTH{1'b0}}, is_div};

   assign prod   = {acc_q, wrk_q};
   assign prod_n = ~prod + 1'b1;
   assign quo    = (is_sgn & (sa_q ^ sb_q)) ? (~wrk_q + 1'b1) : wrk_q;
   assign rem    = (is_sgn & sa_q) ? (~acc_q + 1'b1) : acc_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      araw_d  = araw_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      wrk_d   = wrk_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hi_we) hi_d = wr_data;
            if (lo_we) lo_d = wr_data;
            if (start) begin
               op_d    = op;
               sa_d    = in_sgn & op_a[WIDTH-1];
               sb_d    = in_sgn & op_b[WIDTH-1];
               araw_d  = op_a;
               acc_d   = '0;
               cnt_d   = '0;
               dbz_d   = op[1] & (op_b == '0);
               opnd_d  = op[1] ? abs_b : abs_a;
               wrk_d   = op[1] ? abs_a : abs_b;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (is_div) begin
               if (!add_s[WIDTH]) begin
                  acc_d = add_s[WIDTH-1:0];
                  wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {acc_q[WIDTH-2:0], wrk_q[WIDTH-1]};
                  wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_d = add_s[WIDTH:1];
               wrk_d = {add_s[0], wrk_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (dbz_q) begin
               hi_d = araw_q;
               lo_d = '1;
            end else if (is_div) begin
               hi_d = rem;
               lo_d = quo;
            end else if (is_sgn & (sa_q ^ sb_q)) begin
               hi_d = prod_n[2*WIDTH-1:WIDTH];
               lo_d = prod_n[WIDTH-1:0];
            end else begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         araw_q  <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         wrk_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         araw_q  <= araw_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         wrk_q   <= wrk_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pushed at issue,
// popped and compared when done pulses.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        dbz;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct packed {
      logic        dbz;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .op_a        (op_a),
      .op_b        (op_b),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wr_data     (wr_data),
      .busy        (busy),
      .done        (done),
      .div_by_zero (dbz),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t        e;
      longint      sa;
      longint      sb;
      longint      p;
      longint      q;
      longint      r;
      logic [63:0] up;
      e.dbz = 1'b0;
      e.hi  = '0;
      e.lo  = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (o[1] && b == 32'd0) begin
         e.dbz = 1'b1;
         e.hi  = a;
         e.lo  = 32'hFFFF_FFFF;
      end else if (o == 2'd0) begin
         p    = sa * sb;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (o == 2'd1) begin
         up   = {32'd0, a} * {32'd0, b};
         e.hi = up[63:32];
         e.lo = up[31:0];
      end else if (o == 2'd2) begin
         q    = sa / sb;
         r    = sa % sb;
         e.lo = q[31:0];
         e.hi = r[31:0];
      end else begin
         e.lo = a / b;
         e.hi = a % b;
      end
      return e;
   endfunction

   task automatic issue(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
      start = 1'b1;
      op    = o;
      op_a  = a;
      op_b  = b;
      sb_q.push_back(model(o, a, b));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int pre);
      int   edges;
      int   bcnt;
      exp_t e;
      edges = pre;
      bcnt  = pre;
      while (!done && edges < 40) begin
         if (busy) bcnt++;
         op_a = $urandom;
         op_b = $urandom;
         @(negedge clk);
         edges++;
      end
      check({tag, " done_seen"}, 64'(done), 64'd1);
      if (!done) begin
         if (sb_q.size() > 0) void'(sb_q.pop_front());
         return;
      end
      check({tag, " latency"}, 64'(edges), 64'd33);
      check({tag, " busy_cycles"}, 64'(bcnt), 64'd33);
      check({tag, " busy_at_done"}, 64'(busy), 64'd0);
      check({tag, " sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      check({tag, " hi"}, 64'(hi), 64'(e.hi));
      check({tag, " lo"}, 64'(lo), 64'(e.lo));
      check({tag, " dbz"}, 64'(dbz), 64'(e.dbz));
   endtask

   logic [1:0]  sp_op [6];
   logic [31:0] sp_a  [6];
   logic [31:0] sp_b  [6];

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      op      = 2'd0;
      op_a    = '0;
      op_b    = '0;
      hi_we   = 1'b0;
      lo_we   = 1'b0;
      wr_data = '0;
      repeat (2) @(negedge clk);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst dbz", 64'(dbz), 64'd0);
      check("rst hi", 64'(hi), 64'd0);
      check("rst lo", 64'(lo), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("multu_max", 0);
      check("multu_max hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFE);
      check("multu_max lo_k", 64'(lo), 64'h1);
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd0);

      issue(2'd0, -32'sd3, 32'd5);
      wait_done("mult_neg", 0);
      check("mult_neg hi_k", 64'(hi), 64'hFFFF_FFFF);
      check("mult_neg lo_k", 64'(lo), 64'hFFFF_FFF1);
      issue(2'd2, -32'sd7, 32'd2);
      check("b2b done_low", 64'(done), 64'd0);
      check("b2b busy", 64'(busy), 64'd1);
      wait_done("div_neg", 0);
      check("div_neg lo_k", 64'(lo), 64'hFFFF_FFFD);
      check("div_neg hi_k", 64'(hi), 64'hFFFF_FFFF);

      @(negedge clk);
      issue(2'd3, 32'd100, 32'd0);
      check("dbz_set", 64'(dbz), 64'd1);
      wait_done("divu_zero", 0);
      @(negedge clk);
      issue(2'd3, 32'd100, 32'd7);
      check("dbz_clear", 64'(dbz), 64'd0);
      wait_done("divu_7", 0);
      check("divu_7 hi_k", 64'(hi), 64'd2);
      check("divu_7 lo_k", 64'(lo), 64'd14);

      @(negedge clk);
      issue(2'd1, 32'd6, 32'd7);
      repeat (9) @(negedge clk);
      start = 1'b1;
      op    = 2'd2;
      op_a  = 32'd55;
      op_b  = 32'd3;
      @(negedge clk);
      start   = 1'b0;
      hi_we   = 1'b1;
      wr_data = 32'h0000_DEAD;
      @(negedge clk);
      hi_we = 1'b0;
      wait_done("busy_ignore", 11);
      check("busy_ignore hi_k", 64'(hi), 64'd0);
      check("busy_ignore lo_k", 64'(lo), 64'd42);

      @(negedge clk);
      hi_we   = 1'b1;
      wr_data = 32'h0000_1234;
      @(negedge clk);
      hi_we   = 1'b0;
      lo_we   = 1'b1;
      wr_data = 32'h0000_5678;
      check("mthi hi", 64'(hi), 64'h1234);
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo lo", 64'(lo), 64'h5678);
      check("mtlo hi_kept", 64'(hi), 64'h1234);
      check("mt done", 64'(done), 64'd0);
      hi_we   = 1'b1;
      lo_we   = 1'b1;
      wr_data = 32'h0000_9ABC;
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
      check("mt_both hi", 64'(hi), 64'h9ABC);
      check("mt_both lo", 64'(lo), 64'h9ABC);
      check("mt_both done", 64'(done), 64'd0);

      issue(2'd2, 32'd1000, 32'd7);
      repeat (19) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst busy", 64'(busy), 64'd0);
      check("arst done", 64'(done), 64'd0);
      check("arst hi", 64'(hi), 64'd0);
      check("arst lo", 64'(lo), 64'd0);
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst busy", 64'(busy), 64'd0);
      check("post_rst done", 64'(done), 64'd0);
      issue(2'd0, 32'd2, 32'd3);
      wait_done("mult_after_rst", 0);
      check("mult_after_rst lo_k", 64'(lo), 64'd6);

      sp_op[0] = 2'd2; sp_a[0] = 32'h8000_0000; sp_b[0] = 32'hFFFF_FFFF;
      sp_op[1] = 2'd0; sp_a[1] = 32'h8000_0000; sp_b[1] = 32'h8000_0000;
      sp_op[2] = 2'd0; sp_a[2] = 32'h7FFF_FFFF; sp_b[2] = 32'h8000_0000;
      sp_op[3] = 2'd2; sp_a[3] = 32'h8000_0000; sp_b[3] = 32'h0000_0000;
      sp_op[4] = 2'd2; sp_a[4] = 32'h0000_0007; sp_b[4] = 32'hFFFF_FFFE;
      sp_op[5] = 2'd3; sp_a[5] = 32'hFFFF_FFFF; sp_b[5] = 32'h0000_0001;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         issue(sp_op[i], sp_a[i], sp_b[i]);
         wait_done($sformatf("special%0d", i), 0);
         if (i == 0) begin
            check("min_div lo_k", 64'(lo), 64'h8000_0000);
            check("min_div hi_k", 64'(hi), 64'd0);
            check("min_div dbz_k", 64'(dbz), 64'd0);
         end
         if (i == 1) begin
            check("min_mul hi_k", 64'(hi), 64'h4000_0000);
            check("min_mul lo_k", 64'(lo), 64'd0);
         end
      end

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         issue(2'($urandom_range(0, 3)), $urandom, $urandom);
         wait_done($sformatf("rand%0d", i), 0);
      end

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
